decrypt_stream_checker: RTL and testbench

Sits directly downstream of the decrypter in the RC4 key-search datapath. It snoops the decrypter's write stream into the decrypted RAM (address, data, write-enable) and validates each plaintext byte as it is produced. A key is rejected the moment a bad byte appears, so the cracker FSM can abandon that key early. This replaces the post-hoc RAM sweep with zero extra cycles per accepted key.

---
 rtl/rc4_pkg.sv | 19 +
 rtl/ascii_classifier.sv | 14 +
 rtl/decrypt_stream_checker.sv | 94 +++++++++
 tb/tb_decrypt_stream_checker.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 key-search datapath: checker states, message
// length and the legal plaintext character set.
package rc4_pkg;

  localparam int MESSAGE_LEN = 32;

  localparam logic [7:0] LOW_CHAR   = 8'h61;
  localparam logic [7:0] HIGH_CHAR  = 8'h7A;
  localparam logic [7:0] SPACE_CHAR = 8'h20;

  // Bit 1 marks a verdict, bit 2 marks a reject, so outputs decode from single flops.
  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    CHECK = 3'b001,
    PASS  = 3'b010,
    FAIL  = 3'b110
  } checker_state_t;

endpackage

// File: rtl/ascii_classifier.sv
// Combinational plaintext character check: a lowercase letter or a space.
module ascii_classifier #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] LOW_CHAR   = rc4_pkg::LOW_CHAR,
  parameter logic [DATA_WIDTH-1:0] HIGH_CHAR  = rc4_pkg::HIGH_CHAR,
  parameter logic [DATA_WIDTH-1:0] SPACE_CHAR = rc4_pkg::SPACE_CHAR
) (
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  is_legal
);

  assign is_legal = (data == SPACE_CHAR) || ((data >= LOW_CHAR) && (data <= HIGH_CHAR));

endmodule

// File: rtl/decrypt_stream_checker.sv
// Snoops the decrypter's RAM write stream and rejects a key on the first
// illegal or out-of-order plaintext byte.
//
// state | meaning
// IDLE  | no key under test; captured results held
// CHECK | validating bytes as the decrypter writes them
// PASS  | MESSAGE_LEN legal in-order bytes seen; sticky while start=1
// FAIL  | bad byte captured; sticky while start=1
module decrypt_stream_checker #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    MESSAGE_LEN = rc4_pkg::MESSAGE_LEN,
  parameter logic [DATA_WIDTH-1:0] LOW_CHAR    = rc4_pkg::LOW_CHAR,
  parameter logic [DATA_WIDTH-1:0] HIGH_CHAR   = rc4_pkg::HIGH_CHAR,
  parameter logic [DATA_WIDTH-1:0] SPACE_CHAR  = rc4_pkg::SPACE_CHAR
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  finish,
  output logic                  failure,
  output logic                  abort,
  output logic [ADDR_WIDTH-1:0] bad_index,
  output logic [DATA_WIDTH-1:0] bad_byte,
  output logic [ADDR_WIDTH:0]   byte_count
);
  import rc4_pkg::*;

  localparam logic [ADDR_WIDTH:0] LAST_COUNT = (ADDR_WIDTH+1)'(MESSAGE_LEN);

  checker_state_t            state;
  logic                      is_legal;
  logic                      in_order;
  logic [ADDR_WIDTH:0]       next_count;

  ascii_classifier #(
    .DATA_WIDTH (DATA_WIDTH),
    .LOW_CHAR   (LOW_CHAR),
    .HIGH_CHAR  (HIGH_CHAR),
    .SPACE_CHAR (SPACE_CHAR)
  ) u_classifier (
    .data     (in_data),
    .is_legal (is_legal)
  );

  assign in_order   = (in_addr == byte_count[ADDR_WIDTH-1:0]);
  assign next_count = byte_count + (ADDR_WIDTH+1)'(1);

  assign finish  = state[1];
  assign failure = state[2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      abort      <= 1'b0;
      bad_index  <= '0;
      bad_byte   <= '0;
      byte_count <= '0;
    end else begin
      abort <= 1'b0;
      if (!start) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            // The decrypter never writes in its first started cycle.
            state      <= CHECK;
            byte_count <= '0;
            bad_index  <= '0;
            bad_byte   <= '0;
          end
          CHECK: begin
            if (in_valid) begin
              if (is_legal && in_order) begin
                byte_count <= next_count;
                if (next_count == LAST_COUNT) state <= PASS;
              end else begin
                bad_index <= in_addr;
                bad_byte  <= in_data;
                abort     <= 1'b1;
                state     <= FAIL;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decrypt_stream_checker.sv
// Scoreboard bench for decrypt_stream_checker: expected verdicts are derived
// from each stimulus stream, queued, and compared once the stream completes.
module tb_decrypt_stream_checker;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_addr = '0;
  logic [7:0] in_data = '0;
  logic       finish, failure, abort;
  logic [7:0] bad_index, bad_byte;
  logic [8:0] byte_count;

  decrypt_stream_checker dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .finish     (finish),
    .failure    (failure),
    .abort      (abort),
    .bad_index  (bad_index),
    .bad_byte   (bad_byte),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled away from the active edge.
  int abort_cnt = 0, abort_cyc = -1, finish_cyc = -1;
  bit finish_seen = 1'b0;
  always @(negedge clk) begin
    if (abort) begin
      abort_cnt++;
      if (abort_cyc < 0) abort_cyc = cyc;
    end
    if (finish && !finish_seen) begin
      finish_seen = 1'b1;
      finish_cyc  = cyc;
    end
  end

  typedef struct {
    logic       finish;
    logic       failure;
    logic [8:0] count;
    logic [7:0] bi;
    logic [7:0] bb;
    int         aborts;
    int         decide;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] msg_q[$];
  logic [7:0] addr_q[$];
  int         edge_arr[64];

  function automatic logic legal_char(input logic [7:0] d);
    return (d == 8'h20) || (d >= 8'h61 && d <= 8'h7A);
  endfunction

  task automatic load_string(input string s);
    msg_q.delete();
    addr_q.delete();
    for (int i = 0; i < s.len(); i++) begin
      msg_q.push_back(s[i]);
      addr_q.push_back(8'(i));
    end
  endtask

  task automatic load_fill(input logic [7:0] first);
    msg_q.delete();
    addr_q.delete();
    for (int i = 0; i < 32; i++) begin
      msg_q.push_back(i == 0 ? first : 8'h61);
      addr_q.push_back(8'(i));
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] d, input int gap, output int e);
    @(negedge clk);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    @(posedge clk);
    #1;
    e = cyc;
    in_valid = 1'b0;
    repeat (gap - 1) @(posedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_finish"},  32'(finish),     0);
    check_eq({tag, "_failure"}, 32'(failure),    0);
    check_eq({tag, "_abort"},   32'(abort),      0);
    check_eq({tag, "_count"},   32'(byte_count), 0);
    check_eq({tag, "_bad_idx"}, 32'(bad_index),  0);
    check_eq({tag, "_bad_byte"},32'(bad_byte),   0);
  endtask

  task automatic begin_key(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    check_eq({tag, "_clr_count"},  32'(byte_count), 0);
    check_eq({tag, "_clr_badidx"}, 32'(bad_index),  0);
    check_eq({tag, "_clr_finish"}, 32'(finish),     0);
  endtask

  task automatic end_key(input string tag, input logic [8:0] count, input logic [7:0] bi);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check_eq({tag, "_idle_finish"},  32'(finish),     0);
    check_eq({tag, "_idle_failure"}, 32'(failure),    0);
    check_eq({tag, "_hold_count"},   32'(byte_count), 32'(count));
    check_eq({tag, "_hold_badidx"},  32'(bad_index),  32'(bi));
  endtask

  task automatic run_key(input string tag, input int gap);
    exp_t       x;
    logic [8:0] cnt;
    int         e;
    x.finish = 1'b0; x.failure = 1'b0; x.bi = '0; x.bb = '0;
    x.aborts = 0;    x.decide = -1;    cnt = '0;
    for (int i = 0; i < msg_q.size(); i++) begin
      if (x.decide < 0) begin
        if (legal_char(msg_q[i]) && addr_q[i] == cnt[7:0]) begin
          cnt++;
          if (cnt == 9'd32) begin
            x.finish = 1'b1;
            x.decide = i;
          end
        end else begin
          x.finish = 1'b1; x.failure = 1'b1;
          x.bi = addr_q[i]; x.bb = msg_q[i];
          x.aborts = 1;     x.decide = i;
        end
      end
    end
    x.count = cnt;
    sb.push_back(x);

    abort_cnt = 0; abort_cyc = -1; finish_seen = 1'b0; finish_cyc = -1;
    begin_key(tag);
    for (int i = 0; i < msg_q.size(); i++) begin
      send(addr_q[i], msg_q[i], gap, e);
      edge_arr[i] = e;
    end
    repeat (3) @(posedge clk);
    #1;

    x = sb.pop_front();
    check_eq({tag, "_finish"},  32'(finish),     32'(x.finish));
    check_eq({tag, "_failure"}, 32'(failure),    32'(x.failure));
    check_eq({tag, "_count"},   32'(byte_count), 32'(x.count));
    check_eq({tag, "_bad_idx"}, 32'(bad_index),  32'(x.bi));
    check_eq({tag, "_bad_byte"},32'(bad_byte),   32'(x.bb));
    check_eq({tag, "_aborts"},  32'(abort_cnt),  32'(x.aborts));
    if (x.decide >= 0) check_eq({tag, "_verdict_cyc"}, 32'(finish_cyc), 32'(edge_arr[x.decide]));
    if (x.aborts > 0)  check_eq({tag, "_abort_cyc"},   32'(abort_cyc),  32'(edge_arr[x.decide]));
    end_key(tag, x.count, x.bi);
  endtask

  logic [7:0] bounds[6] = '{8'h60, 8'h7B, 8'h1F, 8'h61, 8'h7A, 8'h20};
  string      hello = "hello world hello world abcdefgh";

  initial begin
    int e;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    reset_n = 1'b1;

    load_string(hello);
    run_key("hello", 3);

    load_string(hello);
    msg_q[5] = 8'h41;
    run_key("upper_a", 1);

    for (int b = 0; b < 6; b++) begin
      load_fill(bounds[b]);
      run_key($sformatf("bound_%02h", bounds[b]), 1);
    end

    load_string("abc");
    addr_q[2] = 8'd3;
    run_key("skip_addr", 2);

    load_string(hello);
    msg_q = msg_q[0:9];
    addr_q = addr_q[0:9];
    run_key("abandon", 1);
    load_string(hello);
    run_key("rerun", 1);

    load_string(hello);
    begin_key("rst");
    for (int i = 0; i < 12; i++) send(addr_q[i], msg_q[i], 1, e);
    check_eq("rst_pre_count", 32'(byte_count), 12);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("rst_async");
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    send(8'd0, 8'h61, 1, e);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_idle_count",  32'(byte_count), 0);
    check_eq("rst_idle_finish", 32'(finish),     0);
    load_string(hello);
    run_key("post_rst", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
